// File: rtl/fetch_ir_pkg.sv
// fetch_ir_pkg: fetch FSM state encoding and the opcode constants shared across the processor.
package fetch_ir_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;
  localparam logic [3:0] OP_ANDI = 4'h2;
  localparam logic [3:0] OP_ORI  = 4'h3;
  // Logical immediates are zero-extended; every other opcode sign-extends.
  function automatic logic ext_sign_of(input logic [3:0] op);
    return !(op == OP_ANDI || op == OP_ORI);
  endfunction
endpackage

// File: rtl/fetch_ir.sv
// fetch_ir: PC register, instruction-fetch FSM and instruction register with inline field decode.
module fetch_ir
  import fetch_ir_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [15:0] pc_next,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] pc,
  output logic [15:0] instr,
  output logic        ir_valid,
  output logic        busy,
  output logic [3:0]  opcode,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [4:0]  imm5,
  output logic        ext_sign
);
  state_t      r_state, w_next;
  logic [15:0] r_pc, r_instr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next   = (r_state == S_IDLE)  ? (fetch_start ? S_FETCH : S_IDLE) :
               (r_state == S_FETCH) ? (mem_ack ? S_DONE : S_FETCH) : S_IDLE;
    mem_req  = r_state == S_FETCH;
    ir_valid = r_state == S_DONE;
    busy     = r_state != S_IDLE;
  end
  // The PC is frozen during FETCH so the read address stays stable until the ack.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else if (r_state == S_FETCH) begin
      if (mem_ack) begin
        r_instr <= mem_rdata;
        r_pc    <= r_pc + PC_STEP;
      end
    end else if (pc_load) r_pc <= pc_next;
  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign instr    = r_instr;
  assign opcode   = r_instr[15:12];
  assign rd       = r_instr[11:9];
  assign rs1      = r_instr[8:6];
  assign imm5     = r_instr[4:0];
  assign ext_sign = ext_sign_of(r_instr[15:12]);
endmodule

// File: doc/fetch_ir.md
FETCH_IR -- requirements
Module: fetch_ir

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 16'h0001, meaning PC increment per fetched word (word addressing).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have port fetch_start, input, 1, meaning a control-unit request to fetch the next instruction.
REQ-006 SHALL have port pc_load, input, 1, meaning load pc_next into PC (branch/jump).
REQ-007 SHALL have port pc_next, input, 16, meaning the target PC value.
REQ-008 SHALL have port mem_req, output, 1, meaning instruction memory read request.
REQ-009 SHALL have port mem_addr, output, 16, meaning the read address.
REQ-010 SHALL have port mem_ack, input, 1, meaning read data valid this cycle.
REQ-011 SHALL have port mem_rdata, input, 16, meaning the instruction word.
REQ-012 SHALL have port pc, output, 16, meaning the current PC register.
REQ-013 SHALL have port instr, output, 16, meaning the instruction register (IR).
REQ-014 SHALL have port ir_valid, output, 1, meaning a one-cycle pulse when IR has just been updated.
REQ-015 SHALL have port busy, output, 1, meaning high whenever the state is not IDLE.
REQ-016 SHALL have port opcode, output, 4, meaning IR[15:12].
REQ-017 SHALL have port rd, output, 3, meaning IR[11:9].
REQ-018 SHALL have port rs1, output, 3, meaning IR[8:6].
REQ-019 SHALL have port imm5, output, 5, meaning IR[4:0], fed to the immediate extender.
REQ-020 SHALL have port ext_sign, output, 1, meaning extender sign select.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH and DONE.
REQ-022 SHALL transition IDLE->FETCH on fetch_start, FETCH->DONE on mem_ack, DONE->IDLE unconditionally.
REQ-023 SHALL drive mem_req=1 throughout FETCH, held until mem_ack, and 0 in all other states.
REQ-024 SHALL drive mem_addr=pc, stable throughout FETCH.
REQ-025 SHALL, on the mem_ack cycle in FETCH, capture instr<=mem_rdata and pc<=pc+PC_STEP, modulo 2^16 (16'hFFFF+1 -> 16'h0000).
REQ-026 SHALL ignore mem_ack outside FETCH.
REQ-027 SHALL assert ir_valid only in DONE, so minimum latency is fetch_start to ir_valid = 2 cycles with a zero-wait ack.
REQ-028 SHALL ignore fetch_start in FETCH and DONE; no queuing.
REQ-029 SHALL apply pc_load in IDLE and DONE; pc_load in FETCH is ignored.
REQ-030 SHALL, on pc_load and fetch_start together in IDLE, load pc_next and issue the fetch with mem_addr=pc_next.
REQ-031 SHALL decode fields combinationally from instr; instr holds its value between fetches.
REQ-032 SHALL drive ext_sign=0 for opcode ANDI (4'h2) and ORI (4'h3), and 1 for all other opcodes.

Reset
REQ-033 SHALL, on rst_n low, asynchronously set state=IDLE, pc=RESET_PC, instr=16'h0000, mem_req=0, ir_valid=0 and busy=0.
REQ-034 SHALL, on reset mid-FETCH, drop mem_req immediately and leave instr unchanged by any ack arriving after reset deassertion.

Structure
REQ-035 SHALL take opcode constants (ANDI, ORI, …) and the FSM state encoding from the shared processor package.
REQ-036 SHALL have no sub-module; field decode is inline, and the immediate extender is instantiated by the datapath, not here.

Verification
REQ-037 SHALL cover reset then fetch_start with zero-wait ack and mem_rdata=16'h2A45 -> mem_addr=0000, ir_valid two cycles after start, opcode=2, rd=5, rs1=1, imm5=5'b00101, ext_sign=0, pc=0001.
REQ-038 SHALL cover ack delayed 3 cycles -> mem_req held 4 cycles, mem_addr constant, busy high, single ir_valid pulse.
REQ-039 SHALL cover pc_load=1, pc_next=16'h00F0 with fetch_start in IDLE -> mem_addr=00F0, pc=00F1 after ack.
REQ-040 SHALL cover pc=16'hFFFF fetch -> pc=0000 after ack.
REQ-041 SHALL cover fetch_start and pc_load pulsed during FETCH -> no effect on mem_addr, pc or the following state.
REQ-042 SHALL cover rst_n low for one cycle mid-FETCH -> mem_req=0 at once, pc=RESET_PC, instr=0000, state IDLE.
